soc_system_pio_led_pwm: RTL and testbench

//  Parametrised Avalon-MM slave output PIO for board LEDs.

---
 rtl/soc_system_pio_pkg.sv | 15 +
 rtl/soc_system_pio_blink_timer.sv | 42 ++++
 rtl/soc_system_pio_led_pwm.sv | 103 ++++++++++
 tb/tb_soc_system_pio_led_pwm.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/soc_system_pio_pkg.sv
// Shared register map and STATUS bit layout for the LED PIO with blink and PWM.
package soc_system_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_OUTSET    = 3'd1;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd2;
  localparam logic [2:0] ADDR_BLINKMASK = 3'd3;
  localparam logic [2:0] ADDR_BLINK_DIV = 3'd4;
  localparam logic [2:0] ADDR_DUTY      = 3'd5;
  localparam logic [2:0] ADDR_STATUS    = 3'd6;

  localparam int STATUS_PHASE_BIT  = 0;
  localparam int STATUS_PWM_ON_BIT = 1;

endpackage

// File: rtl/soc_system_pio_blink_timer.sv
// Blink prescaler: phase toggles every div+1 clocks; div==0 parks phase high.
module soc_system_pio_blink_timer #(
  parameter int PRESCALE_BITS = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PRESCALE_BITS-1:0] div,
  input  logic                     restart,
  output logic                     phase
);

  logic [PRESCALE_BITS-1:0] cnt_q, cnt_d;
  logic                     phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    // restart beats terminal count so a new divider always starts a clean half-period
    if (restart || (div == '0)) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == div) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + PRESCALE_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/soc_system_pio_led_pwm.sv
// Avalon-MM output PIO for LEDs with atomic set/clear, per-bit blink and global PWM dimming.
module soc_system_pio_led_pwm
  import soc_system_pio_pkg::*;
#(
  parameter int               WIDTH         = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE   = 10'h33F,
  parameter int               PWM_BITS      = 8,
  parameter int               PRESCALE_BITS = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]         data_q, data_d;
  logic [WIDTH-1:0]         mask_q, mask_d;
  logic [PRESCALE_BITS-1:0] div_q, div_d;
  logic [PWM_BITS-1:0]      duty_q, duty_d;
  logic [PWM_BITS-1:0]      pwm_cnt_q, pwm_cnt_d;
  logic [WIDTH-1:0]         out_q, out_d;

  logic wr;
  logic restart;
  logic phase;
  logic pwm_on;

  assign wr      = chipselect & ~write_n;
  assign restart = wr && (address == ADDR_BLINK_DIV);

  soc_system_pio_blink_timer #(
    .PRESCALE_BITS(PRESCALE_BITS)
  ) u_blink (
    .clk    (clk),
    .reset  (reset),
    .div    (div_q),
    .restart(restart),
    .phase  (phase)
  );

  // all-ones duty short-circuits the compare so full brightness has no 1-clk dip
  assign pwm_on = (duty_q == {PWM_BITS{1'b1}}) || (pwm_cnt_q < duty_q);

  always_comb begin
    data_d    = data_q;
    mask_d    = mask_q;
    div_d     = div_q;
    duty_d    = duty_q;
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    if (wr) begin
      case (address)
        ADDR_DATA:      data_d = writedata[WIDTH-1:0];
        ADDR_OUTSET:    data_d = data_q | writedata[WIDTH-1:0];
        ADDR_OUTCLEAR:  data_d = data_q & ~writedata[WIDTH-1:0];
        ADDR_BLINKMASK: mask_d = writedata[WIDTH-1:0];
        ADDR_BLINK_DIV: div_d  = writedata[PRESCALE_BITS-1:0];
        ADDR_DUTY:      duty_d = writedata[PWM_BITS-1:0];
        default: ;
      endcase
    end
    out_d = data_q & (~mask_q | {WIDTH{phase}}) & {WIDTH{pwm_on}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= RESET_VALUE;
      mask_q    <= '0;
      div_q     <= '0;
      duty_q    <= '1;
      pwm_cnt_q <= '0;
      out_q     <= RESET_VALUE;
    end else begin
      data_q    <= data_d;
      mask_q    <= mask_d;
      div_q     <= div_d;
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
      out_q     <= out_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:      readdata[WIDTH-1:0]         = data_q;
      ADDR_BLINKMASK: readdata[WIDTH-1:0]         = mask_q;
      ADDR_BLINK_DIV: readdata[PRESCALE_BITS-1:0] = div_q;
      ADDR_DUTY:      readdata[PWM_BITS-1:0]      = duty_q;
      ADDR_STATUS: begin
        readdata[STATUS_PHASE_BIT]  = phase;
        readdata[STATUS_PWM_ON_BIT] = pwm_on;
      end
      default: ;
    endcase
  end

  assign out_port = out_q;

endmodule

// File: tb/tb_soc_system_pio_led_pwm.sv
// Directed bench for the LED PIO: register access, set/clear, blink timing, PWM duty and reset.
module tb_soc_system_pio_led_pwm;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  out_port;

  int tests = 0;
  int fails = 0;

  soc_system_pio_led_pwm dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives on a falling edge; the write lands on the following rising edge and the task
  // returns on the falling edge right after it.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  logic [31:0] r;
  int          hi;

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: reset state; pwm_on reads 1 because duty resets to all-ones
    chk("rst_out", 32'(out_port), 32'h33F);
    rd(3'd0, r); chk("rst_data", r, 32'h33F);
    rd(3'd3, r); chk("rst_mask", r, 32'h0);
    rd(3'd4, r); chk("rst_div", r, 32'h0);
    rd(3'd5, r); chk("rst_duty", r, 32'hFF);
    rd(3'd6, r); chk("rst_status", r, 32'h3);
    rd(3'd7, r); chk("rst_rsvd", r, 32'h0);
    $display("[TB] reset checks done");

    // 2: DATA / OUTSET / OUTCLEAR
    wr(3'd0, 32'h0);
    wr(3'd1, 32'hFFFF_F005);
    wr(3'd2, 32'h1);
    chk("setclr_out_n1", 32'(out_port), 32'h005);
    rd(3'd0, r); chk("setclr_data", r, 32'h004);
    rd(3'd1, r); chk("outset_rd0", r, 32'h0);
    rd(3'd2, r); chk("outclr_rd0", r, 32'h0);
    @(negedge clk);
    chk("setclr_out_n2", 32'(out_port), 32'h004);
    $display("[TB] set/clear data=0x%0h out=0x%0h", r, out_port);

    // 3: blink with div=3, half-period 4 clks
    wr(3'd0, 32'h3FF);
    wr(3'd3, 32'h00F);
    wr(3'd4, 32'h3);
    for (int j = 0; j <= 12; j++) begin
      if (j > 0) @(negedge clk);
      rd(3'd6, r);
      chk("blink_phase", {31'b0, r[0]}, (((j / 4) % 2) == 0) ? 32'h1 : 32'h0);
      chk("blink_out", 32'(out_port),
          (j == 0 || (((j - 1) / 4) % 2) == 0) ? 32'h3FF : 32'h3F0);
    end
    $display("[TB] blink div=3 sequence done");
    wr(3'd4, 32'h0);
    @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      rd(3'd6, r);
      chk("steady_phase", {31'b0, r[0]}, 32'h1);
      chk("steady_out", 32'(out_port), 32'h3FF);
    end
    $display("[TB] blink disabled, steady out=0x%0h", out_port);

    // 5: BLINK_DIV write coincident with terminal count
    wr(3'd4, 32'h3);
    repeat (2) @(negedge clk);
    rd(3'd6, r); chk("tc_pre_phase", {31'b0, r[0]}, 32'h1);
    wr(3'd4, 32'h3);
    rd(3'd6, r); chk("tc_write_wins", {31'b0, r[0]}, 32'h1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      rd(3'd6, r);
      chk("tc_next_toggle", {31'b0, r[0]}, (k < 4) ? 32'h1 : 32'h0);
    end
    $display("[TB] coincident div write done");

    // 4: PWM duty
    wr(3'd4, 32'h0);
    wr(3'd3, 32'h0);
    wr(3'd0, 32'h1);
    wr(3'd5, 32'h40);
    rd(3'd5, r); chk("duty_rd", r, 32'h40);
    repeat (2) @(negedge clk);
    hi = 0;
    for (int j = 0; j < 256; j++) begin
      @(negedge clk);
      if (out_port[0]) hi++;
    end
    chk("pwm_64", 32'(hi), 32'd64);
    $display("[TB] duty=64 high=%0d", hi);

    wr(3'd5, 32'h0);
    repeat (2) @(negedge clk);
    hi = 0;
    for (int j = 0; j < 256; j++) begin
      @(negedge clk);
      if (out_port[0]) hi++;
    end
    chk("pwm_0", 32'(hi), 32'd0);
    $display("[TB] duty=0 high=%0d", hi);

    wr(3'd5, 32'hFFFF_FFFF);
    rd(3'd5, r); chk("duty_trunc", r, 32'hFF);
    repeat (2) @(negedge clk);
    hi = 0;
    for (int j = 0; j < 256; j++) begin
      @(negedge clk);
      if (out_port[0]) hi++;
    end
    chk("pwm_255", 32'(hi), 32'd256);
    $display("[TB] duty=255 high=%0d", hi);

    // 6: reset mid-blink with dimmed PWM
    wr(3'd5, 32'd10);
    wr(3'd3, 32'h0F);
    wr(3'd0, 32'h3FF);
    wr(3'd4, 32'h2);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_out", 32'(out_port), 32'h33F);
    rd(3'd0, r); chk("mrst_data", r, 32'h33F);
    rd(3'd3, r); chk("mrst_mask", r, 32'h0);
    rd(3'd4, r); chk("mrst_div", r, 32'h0);
    rd(3'd5, r); chk("mrst_duty", r, 32'hFF);
    rd(3'd6, r); chk("mrst_status", r, 32'h3);
    $display("[TB] mid-operation reset out=0x%0h", out_port);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
